// File: rtl/bin_to_ascii_field.sv
// Converts a binary (optionally two's-complement) operand into a right-aligned,
// pad-filled ASCII decimal field, one character per internal step tick.
module bin_to_ascii_field #(
  parameter int          DATA_W   = 32,
  parameter int          CHARS    = 64,
  parameter logic [7:0]  PAD_CHAR = 8'h02,
  parameter int          TICK_DIV = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    value,
  input  logic                 is_signed,
  input  logic                 load,
  output logic                 ready,
  output logic                 complete,
  output logic                 overflow,
  output logic [8*CHARS-1:0]   ascii
);

  localparam int IDX_W = $clog2(CHARS + DATA_W + 2);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, SIGN, PUBLISH} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic [DATA_W-1:0] mag, mag_div, mag_rem;
  logic [IDX_W-1:0]  idx;
  logic              neg, ovf_work;
  logic [7:0]        work [CHARS];
  logic [7:0]        step_char;

  assign ready   = (state == IDLE);
  assign tick    = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign mag_div = mag / DATA_W'(10);
  assign mag_rem = mag % DATA_W'(10);

  always_comb begin
    next_state = state;
    step_char  = 8'h2D;
    case (state)
      IDLE:    if (load) next_state = CONVERT;
      CONVERT: begin
        step_char = 8'h30 + 8'(mag_rem);
        if (tick && mag_div == '0) next_state = neg ? SIGN : PUBLISH;
      end
      SIGN:    if (tick) next_state = PUBLISH;
      PUBLISH: if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // The step divider idles at zero so every conversion starts a fresh TICK_DIV period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              tick_cnt <= '0;
    else if (state == IDLE)  tick_cnt <= '0;
    else if (tick)           tick_cnt <= '0;
    else                     tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mag      <= '0;
      idx      <= '0;
      neg      <= 1'b0;
      ovf_work <= 1'b0;
      for (int k = 0; k < CHARS; k++) work[k] <= 8'h00;
    end else begin
      case (state)
        IDLE: if (load) begin
          neg      <= is_signed & value[DATA_W-1];
          mag      <= (is_signed & value[DATA_W-1]) ? -value : value;
          idx      <= '0;
          ovf_work <= 1'b0;
        end
        CONVERT, SIGN: if (tick) begin
          // Characters beyond the field are dropped, keeping the least significant ones.
          if (idx < IDX_W'(CHARS)) begin
            for (int k = 0; k < CHARS; k++)
              if (idx == IDX_W'(k)) work[k] <= step_char;
          end else begin
            ovf_work <= 1'b1;
          end
          idx <= idx + 1'b1;
          if (state == CONVERT) mag <= mag_div;
        end
        default: ;
      endcase
    end
  end

  // Positions at or above idx were not written this conversion and show padding.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ascii    <= {CHARS{PAD_CHAR}};
      complete <= 1'b0;
      overflow <= 1'b0;
    end else begin
      complete <= 1'b0;
      if (state == PUBLISH && tick) begin
        for (int k = 0; k < CHARS; k++)
          ascii[8*k +: 8] <= (IDX_W'(k) < idx) ? work[k] : PAD_CHAR;
        overflow <= ovf_work;
        complete <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_ascii_field.sv
// Scoreboard bench: drivers push reference results, per-DUT monitors check each complete.
module tb_bin_to_ascii_field;

  localparam int         CHARS_A = 8;
  localparam int         TD_A    = 1;
  localparam int         CHARS_B = 12;
  localparam int         TD_B    = 5;
  localparam logic [7:0] PAD     = 8'h20;

  typedef struct {
    logic [95:0] ascii;
    logic        ovf;
    int unsigned due;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       value_a = '0, value_b = '0;
  logic              signed_a = 1'b0, signed_b = 1'b0;
  logic              load_a = 1'b0, load_b = 1'b0;
  logic              ready_a, complete_a, overflow_a;
  logic              ready_b, complete_b, overflow_b;
  logic [8*CHARS_A-1:0] ascii_a;
  logic [8*CHARS_B-1:0] ascii_b;

  exp_t        q_a[$], q_b[$];
  exp_t        ea, eb;
  int unsigned cyc = 0;
  int          pass_cnt = 0, total_cnt = 0;
  logic        changed_b = 1'b0;
  logic [95:0] last_b = {12{PAD}};

  bin_to_ascii_field #(.DATA_W(32), .CHARS(CHARS_A), .PAD_CHAR(PAD), .TICK_DIV(TD_A)) dut_a (
    .clock(clock), .reset(reset), .value(value_a), .is_signed(signed_a), .load(load_a),
    .ready(ready_a), .complete(complete_a), .overflow(overflow_a), .ascii(ascii_a));

  bin_to_ascii_field #(.DATA_W(32), .CHARS(CHARS_B), .PAD_CHAR(PAD), .TICK_DIV(TD_B)) dut_b (
    .clock(clock), .reset(reset), .value(value_b), .is_signed(signed_b), .load(load_b),
    .ready(ready_b), .complete(complete_b), .overflow(overflow_b), .ascii(ascii_b));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: decimal text from the language's own formatter, right-aligned and truncated.
  function automatic exp_t model(input logic [31:0] v, input logic s, input int chars,
                                 input int td, input int unsigned acc);
    string  txt;
    longint n;
    exp_t   e;
    n = s ? longint'($signed(v)) : longint'(v);
    txt = $sformatf("%0d", n);
    e.ascii = '0;
    for (int k = 0; k < chars; k++)
      e.ascii[8*k +: 8] = (k < txt.len()) ? txt[txt.len()-1-k] : PAD;
    e.ovf = (txt.len() > chars);
    e.due = acc + (txt.len() + 1) * td;
    return e;
  endfunction

  task automatic apply_stimulus(input bit sel_b, input logic [31:0] v, input logic s,
                                input bit expect_it);
    int waited = 0;
    @(negedge clock);
    while (!(sel_b ? ready_b : ready_a) && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!(sel_b ? ready_b : ready_a)) begin
      check_output("ready_timeout", 96'd0, 96'd1);
      return;
    end
    if (sel_b) begin value_b = v; signed_b = s; load_b = 1'b1; end
    else       begin value_a = v; signed_a = s; load_a = 1'b1; end
    @(negedge clock);
    load_a = 1'b0;
    load_b = 1'b0;
    if (expect_it) begin
      if (sel_b) q_b.push_back(model(v, s, CHARS_B, TD_B, cyc));
      else       q_a.push_back(model(v, s, CHARS_A, TD_A, cyc));
    end
  endtask

  always @(negedge clock) begin
    if (reset && complete_a) begin
      if (q_a.size() == 0) check_output("a_unexpected_complete", 96'd1, 96'd0);
      else begin
        ea = q_a.pop_front();
        check_output("a_ascii", {32'h0, ascii_a}, ea.ascii);
        check_output("a_overflow", 96'(overflow_a), 96'(ea.ovf));
        check_output("a_latency", 96'(cyc), 96'(ea.due));
        check_output("a_ready_with_complete", 96'(ready_a), 96'd1);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && !complete_b && q_b.size() > 0 && {ascii_b} !== last_b) changed_b = 1'b1;
    if (reset && complete_b) begin
      if (q_b.size() == 0) check_output("b_unexpected_complete", 96'd1, 96'd0);
      else begin
        eb = q_b.pop_front();
        check_output("b_ascii", ascii_b, eb.ascii);
        check_output("b_overflow", 96'(overflow_b), 96'(eb.ovf));
        check_output("b_latency", 96'(cyc), 96'(eb.due));
        check_output("b_ascii_held_during_convert", 96'(changed_b), 96'd0);
        changed_b = 1'b0;
        last_b = eb.ascii;
      end
    end
  end

  task automatic drain();
    int w = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && w < 1000) begin
      @(negedge clock);
      w++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      check_output("drain_timeout", 96'd0, 96'd1);
      q_a.delete();
      q_b.delete();
    end
  endtask

  initial begin
    logic [31:0] rv;
    repeat (3) @(negedge clock);
    check_output("rst_ready_a", 96'(ready_a), 96'd1);
    check_output("rst_complete_a", 96'(complete_a), 96'd0);
    check_output("rst_overflow_a", 96'(overflow_a), 96'd0);
    check_output("rst_ascii_a", {32'h0, ascii_a}, {32'h0, {8{PAD}}});
    check_output("rst_ready_b", 96'(ready_b), 96'd1);
    check_output("rst_ascii_b", ascii_b, {12{PAD}});
    reset = 1'b1;

    apply_stimulus(1'b1, 32'd12345, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h80000000, 1'b1, 1'b1);
    drain();

    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'd12345, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'd7, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'hFFFFFFFF, 1'b1, 1'b1);
    apply_stimulus(1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'd5, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h80000000, 1'b1, 1'b1);

    // A stray load while busy must neither restart nor queue a conversion.
    apply_stimulus(1'b0, 32'd12345, 1'b0, 1'b1);
    @(negedge clock);
    value_a = 32'd99;
    load_a  = 1'b1;
    @(negedge clock);
    load_a  = 1'b0;
    drain();

    for (int i = 0; i < 24; i++) begin
      rv = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 99999));
      apply_stimulus(1'b0, rv, 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();

    apply_stimulus(1'b0, 32'd12345, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check_output("abort_ready", 96'(ready_a), 96'd1);
    check_output("abort_complete", 96'(complete_a), 96'd0);
    check_output("abort_ascii", {32'h0, ascii_a}, {32'h0, {8{PAD}}});
    last_b = {12{PAD}};
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check_output("abort_ascii_after", {32'h0, ascii_a}, {32'h0, {8{PAD}}});
    apply_stimulus(1'b0, 32'd42, 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
